// File: rtl/memory_cycle_if.sv
// Memory-stage bus: execute->memory bundle in,
// stall back to the front end, memory->writeback bundle out.
interface memory_cycle_if;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [5:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [31:0] WriteDataM;
    logic [31:0] ALU_ResultM;
    logic        StallM;
    logic        RegWriteW;
    logic        ResultSrcW;
    logic [5:0]  RD_W;
    logic [31:0] PCPlus4W;
    logic [31:0] ALU_ResultW;
    logic [31:0] ReadDataW;
    logic        AddrErrW;
    logic [31:0] ResultW;

    modport master (
        output RegWriteM, MemWriteM, ResultSrcM, RD_M,
        output PCPlus4M, WriteDataM, ALU_ResultM,
        input  StallM,
        input  RegWriteW, ResultSrcW, RD_W, PCPlus4W,
        input  ALU_ResultW, ReadDataW, AddrErrW, ResultW
    );

    modport slave (
        input  RegWriteM, MemWriteM, ResultSrcM, RD_M,
        input  PCPlus4M, WriteDataM, ALU_ResultM,
        output StallM,
        output RegWriteW, ResultSrcW, RD_W, PCPlus4W,
        output ALU_ResultW, ReadDataW, AddrErrW, ResultW
    );
endinterface

// File: rtl/memory_cycle.sv
// Memory stage: word RAM with configurable access latency,
// front-end stall while an access waits, registered W bundle.
module memory_cycle #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 0
) (
    input  logic           clk,
    input  logic           rst,
    memory_cycle_if.slave  bus
);
    localparam int        AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        access;
    logic        in_range;
    logic        stall;
    logic        complete;
    logic [AW-1:0] idx;
    logic [31:0] rdata;
    logic [31:0] mem [DEPTH];

    assign access   = bus.MemWriteM | bus.ResultSrcM;
    assign idx      = bus.ALU_ResultM[AW+1:2];
    assign in_range = (bus.ALU_ResultM[31:AW+2] == '0);
    // Loads outside the RAM read as zero; non-loads carry no data.
    assign rdata    = (bus.ResultSrcM && in_range) ? mem[idx] : 32'h0;

    // State register for the IDLE/BUSY wait sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state, stall and completion decode.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        stall    = 1'b0;
        complete = 1'b0;
        unique case (state)
            IDLE: begin
                if (access && LATENCY != 0) begin
                    stall   = 1'b1;
                    state_n = BUSY;
                    cnt_n   = 4'd1;
                end else begin
                    complete = 1'b1;
                end
            end
            BUSY: begin
                if (cnt < LAT) begin
                    stall = 1'b1;
                    cnt_n = cnt + 4'd1;
                end else begin
                    complete = 1'b1;
                    state_n  = IDLE;
                    cnt_n    = 4'd0;
                end
            end
        endcase
    end

    // A pending reset abandons the access, so no stall is shown.
    assign bus.StallM = stall & ~rst;

    // Store only on the completion edge so it happens exactly once.
    always_ff @(posedge clk) begin
        if (!rst && complete && bus.MemWriteM && in_range)
            mem[idx] <= bus.WriteDataM;
    end

    // W bundle: capture on completion, bubble while stalled.
    always_ff @(posedge clk) begin
        if (rst || !complete) begin
            bus.RegWriteW   <= 1'b0;
            bus.ResultSrcW  <= 1'b0;
            bus.RD_W        <= 6'd0;
            bus.PCPlus4W    <= 32'h0;
            bus.ALU_ResultW <= 32'h0;
            bus.ReadDataW   <= 32'h0;
            bus.AddrErrW    <= 1'b0;
        end else begin
            bus.RegWriteW   <= bus.RegWriteM;
            bus.ResultSrcW  <= bus.ResultSrcM;
            bus.RD_W        <= bus.RD_M;
            bus.PCPlus4W    <= bus.PCPlus4M;
            bus.ALU_ResultW <= bus.ALU_ResultM;
            bus.ReadDataW   <= rdata;
            bus.AddrErrW    <= access & ~in_range;
        end
    end

    assign bus.ResultW = bus.ResultSrcW ? bus.ReadDataW
                                        : bus.ALU_ResultW;
endmodule
